// File: rtl/jtdsp16_rmove.sv
// JTDSP16 register-to-register move sequencer: decodes the source unit for the
// read mux, captures the selected value and strobes the destination unit.
module jtdsp16_rmove #(
  parameter int             DW       = 16,
  parameter logic [DW-1:0]  BAD_DATA = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          mv_start,
  input  logic [5:0]    src_reg,
  input  logic [5:0]    dst_reg,
  input  logic [DW-1:0] rmux,
  output logic [2:0]    rsel,
  output logic          ready,
  output logic [DW-1:0] rbus,
  output logic [5:0]    dst_addr,
  output logic          we_yaau,
  output logic          we_xaau,
  output logic          we_dau,
  output logic          we_if,
  output logic          done,
  output logic          err,
  output logic          lost
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    WR   = 2'd2
  } state_t;

  localparam logic [2:0] UNIT_YAAU = 3'd0;
  localparam logic [2:0] UNIT_XAAU = 3'd1;
  localparam logic [2:0] UNIT_DAU  = 3'd2;
  localparam logic [2:0] UNIT_IF   = 3'd3;
  localparam logic [2:0] UNIT_NONE = 3'd7;

  // Register code to owning unit; UNIT_NONE marks the unmapped holes 12-15 and 31-63.
  function automatic logic [2:0] unit_of(input logic [5:0] code);
    logic [2:0] unit;
    if (code <= 6'd7)
      unit = UNIT_YAAU;
    else if (code <= 6'd11)
      unit = UNIT_XAAU;
    else if ((code >= 6'd16) && (code <= 6'd23))
      unit = UNIT_DAU;
    else if ((code >= 6'd24) && (code <= 6'd30))
      unit = UNIT_IF;
    else
      unit = UNIT_NONE;
    return unit;
  endfunction

  state_t     state_r, state_nx_s;
  logic       accept_s;
  logic [5:0] dst_r;
  logic       bad_r;
  logic [2:0] src_unit_s, dst_unit_s, wr_unit_s;

  assign src_unit_s = unit_of(src_reg);
  assign dst_unit_s = unit_of(dst_reg);
  assign wr_unit_s  = unit_of(dst_r);
  assign ready      = (state_r == IDLE) || (state_r == WR);

  // State register, advancing only on enabled slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_r <= IDLE;
    else if (cen)
      state_r <= state_nx_s;
    else
      state_r <= state_r;
  end

  // Next-state logic; a new move is accepted from IDLE or from the WR slot.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (mv_start) begin
          accept_s   = 1'b1;
          state_nx_s = SEL;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SEL: state_nx_s = WR;
      WR: begin
        if (mv_start) begin
          accept_s   = 1'b1;
          state_nx_s = SEL;
        end else begin
          state_nx_s = IDLE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Datapath: latch the request on accept, capture rmux and pulse strobes out of SEL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsel     <= 3'd0;
      rbus     <= {DW{1'b0}};
      dst_addr <= 6'd0;
      dst_r    <= 6'd0;
      bad_r    <= 1'b0;
      we_yaau  <= 1'b0;
      we_xaau  <= 1'b0;
      we_dau   <= 1'b0;
      we_if    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      lost     <= 1'b0;
    end else if (cen) begin
      // Pulses last exactly one slot unless re-armed below.
      we_yaau <= 1'b0;
      we_xaau <= 1'b0;
      we_dau  <= 1'b0;
      we_if   <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      lost    <= (state_r == SEL) && mv_start;
      if (accept_s) begin
        dst_r <= dst_reg;
        bad_r <= (src_unit_s == UNIT_NONE) || (dst_unit_s == UNIT_NONE);
        rsel  <= (src_unit_s == UNIT_NONE) ? 3'd0 : src_unit_s;
      end
      if (state_r == SEL) begin
        rbus     <= bad_r ? BAD_DATA : rmux;
        dst_addr <= dst_r;
        we_yaau  <= !bad_r && (wr_unit_s == UNIT_YAAU);
        we_xaau  <= !bad_r && (wr_unit_s == UNIT_XAAU);
        we_dau   <= !bad_r && (wr_unit_s == UNIT_DAU);
        we_if    <= !bad_r && (wr_unit_s == UNIT_IF);
        done     <= 1'b1;
        err      <= bad_r;
      end
    end
  end

endmodule

// File: tb/tb_jtdsp16_rmove.sv
// Directed bench for jtdsp16_rmove: hand-computed expectations checked with
// immediate assertions after every clock slot.
module tb_jtdsp16_rmove;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cen = 1'b1;
  logic        mv_start = 1'b0;
  logic [5:0]  src_reg = 6'd0;
  logic [5:0]  dst_reg = 6'd0;
  logic [15:0] rmux;
  logic [2:0]  rsel;
  logic        ready;
  logic [15:0] rbus;
  logic [5:0]  dst_addr;
  logic        we_yaau, we_xaau, we_dau, we_if, done, err, lost;

  int errors = 0;
  int checks = 0;

  jtdsp16_rmove dut (
    .clk(clk), .rst(rst), .cen(cen), .mv_start(mv_start),
    .src_reg(src_reg), .dst_reg(dst_reg), .rmux(rmux),
    .rsel(rsel), .ready(ready), .rbus(rbus), .dst_addr(dst_addr),
    .we_yaau(we_yaau), .we_xaau(we_xaau), .we_dau(we_dau), .we_if(we_if),
    .done(done), .err(err), .lost(lost)
  );

  always #5 clk = ~clk;

  // Read mux model: each unit returns a distinct word so a wrong rsel is visible.
  always_comb begin
    case (rsel)
      3'd0:    rmux = 16'h1234;
      3'd1:    rmux = 16'h5678;
      3'd2:    rmux = 16'h9ABC;
      3'd3:    rmux = 16'hDEF0;
      default: rmux = 16'h0BAD;
    endcase
  end

  // Flag order: {we_yaau, we_xaau, we_dau, we_if, done, err, lost}
  logic [6:0] flags;
  assign flags = {we_yaau, we_xaau, we_dau, we_if, done, err, lost};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [5:0] s, input logic [5:0] d);
    mv_start = 1'b1;
    src_reg  = s;
    dst_reg  = d;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    #1;
    chk("rst_flags", 32'(flags), 32'h00);
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_rsel", 32'(rsel), 32'h0);
    chk("rst_rbus", 32'(rbus), 32'h0);
    chk("rst_dst", 32'(dst_addr), 32'h0);
    step(); step();
    rst = 1'b0;
    step();

    // Basic move j -> yl
    start(6'd4, 6'd18);
    step();
    mv_start = 1'b0;
    chk("m1_rsel", 32'(rsel), 32'h0);
    chk("m1_ready_sel", 32'(ready), 32'h0);
    chk("m1_flags_sel", 32'(flags), 32'h00);
    step();
    chk("m1_flags_wr", 32'(flags), 32'b0010100);
    chk("m1_rbus", 32'(rbus), 32'h1234);
    chk("m1_dst", 32'(dst_addr), 32'd18);
    chk("m1_ready_wr", 32'(ready), 32'h1);
    step();
    chk("m1_flags_after", 32'(flags), 32'h00);
    chk("m1_rbus_hold", 32'(rbus), 32'h1234);

    // Back-to-back: 8 -> 0, then 21 -> 27 accepted in the WR slot
    start(6'd8, 6'd0);
    step();
    mv_start = 1'b0;
    chk("bb1_rsel", 32'(rsel), 32'h1);
    step();
    chk("bb1_flags", 32'(flags), 32'b1000100);
    chk("bb1_rbus", 32'(rbus), 32'h5678);
    chk("bb1_dst", 32'(dst_addr), 32'd0);
    start(6'd21, 6'd27);
    step();
    mv_start = 1'b0;
    chk("bb2_rsel", 32'(rsel), 32'h2);
    chk("bb2_flags_sel", 32'(flags), 32'h00);
    step();
    chk("bb2_flags", 32'(flags), 32'b0001100);
    chk("bb2_rbus", 32'(rbus), 32'h9ABC);
    chk("bb2_dst", 32'(dst_addr), 32'd27);
    step();
    chk("bb_idle_flags", 32'(flags), 32'h00);

    // Unmapped source
    start(6'd13, 6'd0);
    step();
    mv_start = 1'b0;
    chk("bs_rsel", 32'(rsel), 32'h0);
    step();
    chk("bs_flags", 32'(flags), 32'b0000110);
    chk("bs_rbus", 32'(rbus), 32'h0000);
    step();

    // Unmapped destination: rmux would read 16'h1234 but must be replaced
    start(6'd2, 6'd40);
    step();
    mv_start = 1'b0;
    step();
    chk("bd_flags", 32'(flags), 32'b0000110);
    chk("bd_rbus", 32'(rbus), 32'h0000);
    chk("bd_dst", 32'(dst_addr), 32'd40);
    step();

    // cen low: request not accepted
    cen = 1'b0;
    start(6'd21, 6'd0);
    step();
    chk("cen_no_accept_rsel", 32'(rsel), 32'h0);
    chk("cen_no_accept_ready", 32'(ready), 32'h1);

    // cen toggled during a move 9 -> 24
    cen = 1'b1;
    start(6'd9, 6'd24);
    step();
    mv_start = 1'b0;
    cen = 1'b0;
    step();
    chk("cen_sel_rsel", 32'(rsel), 32'h1);
    chk("cen_sel_flags", 32'(flags), 32'h00);
    cen = 1'b1;
    step();
    chk("cen_wr_flags", 32'(flags), 32'b0001100);
    chk("cen_wr_rbus", 32'(rbus), 32'h5678);
    chk("cen_wr_dst", 32'(dst_addr), 32'd24);
    cen = 1'b0;
    step();
    chk("cen_frozen_flags", 32'(flags), 32'b0001100);
    cen = 1'b1;
    step();
    chk("cen_cleared_flags", 32'(flags), 32'h00);

    // src == dst
    start(6'd19, 6'd19);
    step();
    mv_start = 1'b0;
    step();
    chk("same_flags", 32'(flags), 32'b0010100);
    chk("same_rbus", 32'(rbus), 32'h9ABC);
    chk("same_dst", 32'(dst_addr), 32'd19);
    step();

    // mv_start in SEL is dropped and flagged
    start(6'd16, 6'd1);
    step();
    start(6'd3, 6'd17);
    step();
    mv_start = 1'b0;
    chk("lost_flags", 32'(flags), 32'b1000101);
    chk("lost_rbus", 32'(rbus), 32'h9ABC);
    chk("lost_dst", 32'(dst_addr), 32'd1);
    step();
    chk("lost_after_flags", 32'(flags), 32'h00);
    chk("lost_after_rsel", 32'(rsel), 32'h2);
    chk("lost_after_dst", 32'(dst_addr), 32'd1);

    // Reset in SEL discards the move
    start(6'd0, 6'd5);
    step();
    mv_start = 1'b0;
    rst = 1'b1;
    #1;
    chk("rsel_flags", 32'(flags), 32'h00);
    chk("rsel_ready", 32'(ready), 32'h1);
    chk("rsel_rbus", 32'(rbus), 32'h0);
    chk("rsel_dst", 32'(dst_addr), 32'h0);
    step();
    rst = 1'b0;
    step();
    chk("rsel_post1_flags", 32'(flags), 32'h00);
    step();
    chk("rsel_post2_flags", 32'(flags), 32'h00);
    chk("rsel_post_dst", 32'(dst_addr), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
